ibex_fetch_realigner: RTL and testbench

Sits between the prefetch buffer and the compressed decoder. It accepts an in-order stream of 32-bit, word-aligned fetch words and emits one instruction per handshake: either a 16-bit compressed instruction in bits [15:0] or a full 32-bit instruction. It holds a 16-bit residue so that 32-bit instructions straddling a word boundary are reassembled. It tracks the instruction PC, handles flushes to halfword-aligned targets, and propagates fetch bus errors.

---
 rtl/ibex_fetch_realigner.sv | 150 +++++++++++++++
 tb/tb_ibex_fetch_realigner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_realigner.sv
// ibex_fetch_realigner
//   Turns a stream of word-aligned 32-bit fetch words into one RISC-V
//   instruction per output handshake. A 16-bit residue register holds the
//   upper half of a consumed word, so that 32-bit instructions straddling a
//   word boundary can be stitched back together. Also tracks the PC, handles
//   redirects to halfword-aligned targets and carries fetch bus errors along
//   with the instruction that contains the errored half.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i, flush_addr_i  redirect; discards buffered state (bit 0 of addr ignored)
//   fetch_valid_i/ready_o  fetch word handshake; fetch_rdata_i, fetch_err_i
//   out_valid_o/ready_i    instruction handshake
//   out_instr_o            instruction (upper half zero when compressed)
//   out_addr_o             PC of out_instr_o
//   out_is_compressed_o    out_instr_o[1:0] != 2'b11
//   out_err_o              instruction contains an errored fetch half
module ibex_fetch_realigner #(
  parameter logic [31:0] BootAddr = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o
);

  // EMPTY: no residue held. HALF: residue_q holds the next halfword.
  // SKIP: the next fetch word's low half precedes the PC and is dropped.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    SKIP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] residue_q, residue_d;
  logic        residue_err_q, residue_err_d;
  logic [31:0] pc_q, pc_d;

  logic        valid;
  logic [31:0] instr;
  logic        err;
  logic [15:0] word_lo, word_hi;
  logic        unused_flush_bit0;

  function automatic logic is_comp(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  assign word_lo           = fetch_rdata_i[15:0];
  assign word_hi           = fetch_rdata_i[31:16];
  assign unused_flush_bit0 = flush_addr_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BootAddr[1] ? SKIP : EMPTY;
      residue_q     <= '0;
      residue_err_q <= 1'b0;
      pc_q          <= BootAddr;
    end else begin
      state_q       <= state_d;
      residue_q     <= residue_d;
      residue_err_q <= residue_err_d;
      pc_q          <= pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    residue_d     = residue_q;
    residue_err_d = residue_err_q;
    pc_d          = pc_q;
    valid         = 1'b0;
    instr         = '0;
    err           = 1'b0;
    fetch_ready_o = 1'b0;

    if (flush_i) begin
      // Accept and drop whatever is presented so the prefetcher can move on.
      fetch_ready_o = 1'b1;
      pc_d          = {flush_addr_i[31:1], 1'b0};
      residue_d     = '0;
      residue_err_d = 1'b0;
      state_d       = flush_addr_i[1] ? SKIP : EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          valid         = fetch_valid_i;
          err           = fetch_err_i;
          fetch_ready_o = out_ready_i;
          instr         = is_comp(word_lo) ? {16'h0000, word_lo} : fetch_rdata_i;
          if (fetch_valid_i && out_ready_i && is_comp(word_lo)) begin
            residue_d     = word_hi;
            residue_err_d = fetch_err_i;
            state_d       = HALF;
          end
        end
        HALF: begin
          if (is_comp(residue_q)) begin
            // Residue is a whole instruction; the fetch word waits.
            valid = 1'b1;
            instr = {16'h0000, residue_q};
            err   = residue_err_q;
            if (out_ready_i) state_d = EMPTY;
          end else begin
            valid         = fetch_valid_i;
            instr         = {word_lo, residue_q};
            err           = residue_err_q | fetch_err_i;
            fetch_ready_o = out_ready_i;
            if (fetch_valid_i && out_ready_i) begin
              residue_d     = word_hi;
              residue_err_d = fetch_err_i;
            end
          end
        end
        SKIP: begin
          fetch_ready_o = 1'b1;
          if (fetch_valid_i) begin
            residue_d     = word_hi;
            residue_err_d = fetch_err_i;
            state_d       = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase

      if (valid && out_ready_i) begin
        pc_d = pc_q + (is_comp(instr[15:0]) ? 32'd2 : 32'd4);
      end
    end
  end

  // Data outputs are forced to zero while no instruction is offered.
  assign out_valid_o         = valid;
  assign out_instr_o         = valid ? instr : 32'h0;
  assign out_err_o           = valid & err;
  assign out_is_compressed_o = valid & is_comp(instr[15:0]);
  assign out_addr_o          = pc_q;

endmodule

// File: tb/tb_ibex_fetch_realigner.sv
// Testbench for ibex_fetch_realigner: directed vector table, hand-written
// stall/reset sequences, and randomized traffic against a halfword-queue model.
module tb_ibex_fetch_realigner;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush;
  logic [31:0] flush_addr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_is_compressed;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_fetch_realigner #(.BootAddr(32'h0000_0080)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .flush_i            (flush),
    .flush_addr_i       (flush_addr),
    .fetch_valid_i      (fetch_valid),
    .fetch_ready_o      (fetch_ready),
    .fetch_rdata_i      (fetch_rdata),
    .fetch_err_i        (fetch_err),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_instr_o        (out_instr),
    .out_addr_o         (out_addr),
    .out_is_compressed_o(out_is_compressed),
    .out_err_o          (out_err)
  );

  typedef struct {
    logic        fl;
    logic [31:0] fa;
    logic        fv;
    logic [31:0] w;
    logic        fe;
    logic        rdy;
    logic        ev;
    logic        efr;
    logic [31:0] ei;
    logic [31:0] ea;
    logic        ee;
  } vec_t;

  vec_t vecs[20];

  // Reference model: buffered halfwords {err, data}, expected PC, skip flag.
  logic [16:0] hq[$];
  logic [31:0] mpc;
  bit          mskip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic efr,
                               input logic [31:0] ei, input logic [31:0] ea, input logic ee);
    logic ec;
    ec = ev && (ei[1:0] != 2'b11);
    check({tag, " valid"}, {31'b0, out_valid}, {31'b0, ev});
    check({tag, " fetch_ready"}, {31'b0, fetch_ready}, {31'b0, efr});
    check({tag, " addr"}, out_addr, ea);
    if (ev) begin
      check({tag, " instr"}, out_instr, ei);
      check({tag, " err"}, {31'b0, out_err}, {31'b0, ee});
      check({tag, " compressed"}, {31'b0, out_is_compressed}, {31'b0, ec});
    end
  endtask

  task automatic apply(input logic fl, input logic [31:0] fa, input logic fv,
                       input logic [31:0] w, input logic fe, input logic rdy);
    @(negedge clk);
    flush = fl; flush_addr = fa; fetch_valid = fv;
    fetch_rdata = w; fetch_err = fe; out_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    flush = 1'b0; flush_addr = 32'h0; fetch_valid = 1'b0;
    fetch_rdata = 32'h0; fetch_err = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic model_step(input logic fl, input logic [31:0] fa, input logic fv,
                            input logic [31:0] w, input logic fe, input logic rdy,
                            output logic ev, output logic efr, output logic [31:0] ei,
                            output logic [31:0] ea, output logic ee);
    logic [16:0] avail[$];
    logic [16:0] h0, h1;
    int          need;
    bit          word_needed;
    ev = 1'b0; efr = 1'b0; ei = 32'h0; ee = 1'b0; ea = mpc;
    if (fl) begin
      efr = 1'b1;
      hq.delete();
      mpc = {fa[31:1], 1'b0};
      mskip = fa[1];
    end else if (mskip) begin
      efr = 1'b1;
      if (fv) begin
        hq.delete();
        hq.push_back({fe, w[31:16]});
        mskip = 1'b0;
      end
    end else begin
      avail = hq;
      if (fv) begin
        avail.push_back({fe, w[15:0]});
        avail.push_back({fe, w[31:16]});
      end
      need = 1;
      if (avail.size() != 0) begin
        h0 = avail[0];
        need = (h0[1:0] != 2'b11) ? 1 : 2;
      end
      word_needed = hq.size() < need;
      efr = word_needed ? rdy : 1'b0;
      if (avail.size() >= need) begin
        ev = 1'b1;
        h0 = avail[0];
        if (need == 1) begin
          ei = {16'h0, h0[15:0]};
          ee = h0[16];
        end else begin
          h1 = avail[1];
          ei = {h1[15:0], h0[15:0]};
          ee = h0[16] | h1[16];
        end
        if (rdy) begin
          if (word_needed) hq = avail;
          for (int k = 0; k < need; k++) void'(hq.pop_front());
          mpc = mpc + 32'(need * 2);
        end
      end
    end
  endtask

  initial begin
    logic        ev, efr, ee;
    logic [31:0] ei, ea;
    logic        fl, fv, fe, rdy;
    logic [31:0] fa, w;

    vecs[0]  = '{1'b0, 32'h0,        1'b1, 32'h00A00513, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00A00513, 32'h80,       1'b0};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 32'h45014581, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00004581, 32'h84,       1'b0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h00004501, 32'h86,       1'b0};
    vecs[3]  = '{1'b1, 32'h80,       1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h88,       1'b0};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 32'h05134581, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00004581, 32'h80,       1'b0};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 32'h000000A0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00A00513, 32'h82,       1'b0};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h86,       1'b0};
    vecs[7]  = '{1'b1, 32'h103,      1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h86,       1'b0};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 32'h45051234, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h102,      1'b0};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h00004505, 32'h102,      1'b0};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 32'h05134581, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00004581, 32'h104,      1'b0};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 32'h000000A0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00A00513, 32'h106,      1'b1};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h10A,      1'b1};
    vecs[13] = '{1'b0, 32'h0,        1'b1, 32'h45014581, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00004581, 32'h10C,      1'b0};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h00004501, 32'h10E,      1'b0};
    vecs[15] = '{1'b1, 32'hFFFFFFFE, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h110,      1'b0};
    vecs[16] = '{1'b0, 32'h0,        1'b1, 32'h4509FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'hFFFFFFFE, 1'b0};
    vecs[17] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h00004509, 32'hFFFFFFFE, 1'b0};
    vecs[18] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[19] = '{1'b0, 32'h0,        1'b1, 32'h00A00513, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00A00513, 32'h0,        1'b0};

    // Reset state
    do_reset();
    rst_ni = 1'b0;
    #1;
    check_outputs("reset", 1'b0, 1'b0, 32'h0, 32'h80, 1'b0);
    check("reset instr", out_instr, 32'h0);
    check("reset err", {31'b0, out_err}, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].fl, vecs[i].fa, vecs[i].fv, vecs[i].w, vecs[i].fe, vecs[i].rdy);
      check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].efr, vecs[i].ei, vecs[i].ea, vecs[i].ee);
    end

    // Backpressure on a full-width instruction, then exactly one handshake
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 32'h0, 1'b1, 32'h00A00513, 1'b0, 1'b0);
      check_outputs($sformatf("stall%0d", i), 1'b1, 1'b0, 32'h00A00513, 32'h80, 1'b0);
    end
    apply(1'b0, 32'h0, 1'b1, 32'h00A00513, 1'b0, 1'b1);
    check_outputs("stall release", 1'b1, 1'b1, 32'h00A00513, 32'h80, 1'b0);
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_outputs("after release", 1'b0, 1'b0, 32'h0, 32'h84, 1'b0);

    // Backpressure with a compressed residue; the fetch word must not be taken
    apply(1'b0, 32'h0, 1'b1, 32'h45014581, 1'b0, 1'b1);
    check_outputs("half load", 1'b1, 1'b1, 32'h00004581, 32'h84, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 32'h0, 1'b1, 32'h11111113, 1'b0, 1'b0);
      check_outputs($sformatf("half stall%0d", i), 1'b1, 1'b0, 32'h00004501, 32'h86, 1'b0);
    end
    apply(1'b0, 32'h0, 1'b1, 32'h11111113, 1'b0, 1'b1);
    check_outputs("half release", 1'b1, 1'b0, 32'h00004501, 32'h86, 1'b0);
    apply(1'b0, 32'h0, 1'b1, 32'h11111113, 1'b0, 1'b0);
    check_outputs("word kept", 1'b1, 1'b0, 32'h11111113, 32'h88, 1'b0);

    // Flush while an instruction is offered
    apply(1'b1, 32'h200, 1'b1, 32'h11111113, 1'b0, 1'b1);
    check_outputs("flush valid", 1'b0, 1'b1, 32'h0, 32'h88, 1'b0);
    apply(1'b0, 32'h0, 1'b1, 32'h00A00513, 1'b0, 1'b0);
    check_outputs("post flush", 1'b1, 1'b0, 32'h00A00513, 32'h200, 1'b0);

    // Asynchronous reset while holding a compressed residue
    apply(1'b0, 32'h0, 1'b1, 32'h45014581, 1'b0, 1'b1);
    check_outputs("pre reset", 1'b1, 1'b1, 32'h00004581, 32'h200, 1'b0);
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_outputs("in half", 1'b1, 1'b0, 32'h00004501, 32'h202, 1'b0);
    rst_ni = 1'b0;
    #1;
    check_outputs("mid reset", 1'b0, 1'b0, 32'h0, 32'h80, 1'b0);
    check("mid reset instr", out_instr, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check_outputs("reset empty", 1'b0, 1'b0, 32'h0, 32'h80, 1'b0);
    out_ready = 1'b1;
    #1;
    check_outputs("reset empty rdy", 1'b0, 1'b1, 32'h0, 32'h80, 1'b0);
    apply(1'b0, 32'h0, 1'b1, 32'h00A00513, 1'b0, 1'b1);
    check_outputs("reset first", 1'b1, 1'b1, 32'h00A00513, 32'h80, 1'b0);

    // Randomized traffic against the halfword-queue model
    do_reset();
    hq.delete();
    mpc = 32'h80;
    mskip = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      fl  = ($urandom_range(0, 29) == 0);
      fa  = $urandom;
      fv  = ($urandom_range(0, 9) < 7);
      w   = $urandom;
      fe  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      apply(fl, fa, fv, w, fe, rdy);
      model_step(fl, fa, fv, w, fe, rdy, ev, efr, ei, ea, ee);
      check_outputs($sformatf("rand%0d", c), ev, efr, ei, ea, ee);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
